// File: rtl/mem_stage.sv
// mem_stage: MIPS-style memory stage with byte-addressable data memory and M/W pipeline register
// Ports: clk, reset (async, active-low)
//        instr_M, ALUout_M (byte address), WD_M (store data), PC8_M -> memory-stage inputs
//        instr_W, ALUout_W, DR_W (extended load data), PC8_W, addr_err_W -> registered outputs
module mem_stage #(
    parameter int DM_WORDS = 1024,
    parameter int AW       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_M,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] WD_M,
    input  logic [31:0] PC8_M,
    output logic [31:0] instr_W,
    output logic [31:0] ALUout_W,
    output logic [31:0] DR_W,
    output logic [31:0] PC8_W,
    output logic        addr_err_W
);
    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101, LB = 6'b100000,
                           LBU = 6'b100100, SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
    logic [31:0]   mem [DM_WORDS];
    logic [5:0]    op;
    logic [AW-1:0] wa;
    logic [1:0]    off;
    logic          is_word, is_half, is_mem, mis;
    logic [31:0]   rd, rd_sh, ld, wd;
    logic [15:0]   h;
    logic [7:0]    b;
    logic [3:0]    be;
    assign op      = instr_M[31:26];
    assign wa      = ALUout_M[AW+1:2];
    assign off     = ALUout_M[1:0];
    assign is_word = op == LW || op == SW;
    assign is_half = op == LH || op == LHU || op == SH;
    assign is_mem  = is_word || is_half || op == LB || op == LBU || op == SB;
    assign mis     = is_mem && ((is_word && off != 2'd0) || (is_half && off[0]));
    assign rd      = mem[wa];
    assign rd_sh   = rd >> {off, 3'b000};
    assign b       = rd_sh[7:0];
    assign h       = off[1] ? rd[31:16] : rd[15:0];
    always_comb begin
        ld = mis         ? 32'd0 :
             op == LW    ? rd :
             op == LH    ? {{16{h[15]}}, h} :
             op == LHU   ? {16'd0, h} :
             op == LB    ? {{24{b[7]}}, b} :
             op == LBU   ? {24'd0, b} : 32'd0;
        // byte-lane enables; misaligned stores are suppressed entirely
        be = mis      ? 4'b0000 :
             op == SW ? 4'b1111 :
             op == SH ? (off[1] ? 4'b1100 : 4'b0011) :
             op == SB ? 4'(4'b0001 << off) : 4'b0000;
        wd = op == SW ? WD_M : op == SH ? {2{WD_M[15:0]}} : {4{WD_M[7:0]}};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        end else begin
            for (int j = 0; j < 4; j++) if (be[j]) mem[wa][8*j +: 8] <= wd[8*j +: 8];
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_W    <= '0;
            ALUout_W   <= '0;
            DR_W       <= '0;
            PC8_W      <= '0;
            addr_err_W <= 1'b0;
        end else begin
            instr_W    <= instr_M;
            ALUout_W   <= ALUout_M;
            DR_W       <= ld;
            PC8_W      <= PC8_M;
            addr_err_W <= mis;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_M = '0, ALUout_M = '0, WD_M = '0, PC8_M = '0;
    logic [31:0] instr_W, ALUout_W, DR_W, PC8_W;
    logic        addr_err_W;
    int          total = 0, bad = 0;
    logic [31:0] exp_instr, exp_pc8;
    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101, LB = 6'b100000,
                           LBU = 6'b100100, SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;

    mem_stage dut (
        .clk(clk), .reset(reset), .instr_M(instr_M), .ALUout_M(ALUout_M), .WD_M(WD_M),
        .PC8_M(PC8_M), .instr_W(instr_W), .ALUout_W(ALUout_W), .DR_W(DR_W), .PC8_W(PC8_W),
        .addr_err_W(addr_err_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        instr_M   = {op, 26'h0123456};
        ALUout_M  = addr;
        WD_M      = wd;
        PC8_M     = 32'h0040_0008 + addr;
        exp_instr = instr_M;
        exp_pc8   = PC8_M;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ld(input string tag, input logic [31:0] dr, input logic err);
        check({tag, ".dr"}, DR_W, dr);
        check({tag, ".err"}, {31'd0, addr_err_W}, {31'd0, err});
    endtask

    initial begin
        #3;
        check("rst.instr", instr_W, 32'd0);
        check("rst.alu", ALUout_W, 32'd0);
        check("rst.dr", DR_W, 32'd0);
        check("rst.pc8", PC8_W, 32'd0);
        check("rst.err", {31'd0, addr_err_W}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(SW, 32'h10, 32'h1234_5678);  chk_ld("sw10", 32'd0, 1'b0);
        check("pass.instr", instr_W, exp_instr);
        check("pass.alu", ALUout_W, 32'h10);
        check("pass.pc8", PC8_W, exp_pc8);
        do_op(LW, 32'h10, 32'd0);          chk_ld("lw10", 32'h1234_5678, 1'b0);

        do_op(SB, 32'h11, 32'h0000_00AB);  chk_ld("sb11", 32'd0, 1'b0);
        do_op(LB, 32'h11, 32'd0);          chk_ld("lb11", 32'hFFFF_FFAB, 1'b0);
        do_op(LBU, 32'h11, 32'd0);         chk_ld("lbu11", 32'h0000_00AB, 1'b0);
        do_op(LW, 32'h10, 32'd0);          chk_ld("lw10b", 32'h1234_AB78, 1'b0);
        do_op(LB, 32'h13, 32'd0);          chk_ld("lb13", 32'h0000_0012, 1'b0);

        do_op(SH, 32'h22, 32'h0000_8001);  chk_ld("sh22", 32'd0, 1'b0);
        do_op(LH, 32'h22, 32'd0);          chk_ld("lh22", 32'hFFFF_8001, 1'b0);
        do_op(LHU, 32'h22, 32'd0);         chk_ld("lhu22", 32'h0000_8001, 1'b0);
        do_op(LW, 32'h20, 32'd0);          chk_ld("lw20", 32'h8001_0000, 1'b0);
        do_op(LH, 32'h20, 32'd0);          chk_ld("lh20", 32'd0, 1'b0);

        do_op(SW, 32'h31, 32'hDEAD_BEEF);  chk_ld("sw31", 32'd0, 1'b1);
        do_op(LW, 32'h30, 32'd0);          chk_ld("lw30", 32'd0, 1'b0);
        do_op(SH, 32'h33, 32'hFFFF_FFFF);  chk_ld("sh33", 32'd0, 1'b1);
        do_op(LW, 32'h30, 32'd0);          chk_ld("lw30b", 32'd0, 1'b0);
        do_op(LW, 32'h12, 32'd0);          chk_ld("lw12", 32'd0, 1'b1);
        do_op(LH, 32'h11, 32'd0);          chk_ld("lh11", 32'd0, 1'b1);
        do_op(LHU, 32'h23, 32'd0);         chk_ld("lhu23", 32'd0, 1'b1);
        do_op(LB, 32'h33, 32'd0);          chk_ld("lb33", 32'd0, 1'b0);

        do_op(SW, 32'h0000_1004, 32'hCAFE_F00D); chk_ld("sw1004", 32'd0, 1'b0);
        do_op(LW, 32'h0000_0004, 32'd0);         chk_ld("lw4", 32'hCAFE_F00D, 1'b0);
        check("wrap.alu", ALUout_W, 32'h4);

        do_op(LW, 32'h10, 32'd0);          chk_ld("lw10c", 32'h1234_AB78, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mid.instr", instr_W, 32'd0);
        check("mid.alu", ALUout_W, 32'd0);
        check("mid.dr", DR_W, 32'd0);
        check("mid.pc8", PC8_W, 32'd0);
        check("mid.err", {31'd0, addr_err_W}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op(LW, 32'h10, 32'd0);          chk_ld("lw10rst", 32'd0, 1'b0);
        do_op(LW, 32'h4, 32'd0);           chk_ld("lw4rst", 32'd0, 1'b0);
        @(negedge clk);
        instr_M  = 32'h012A_4020;
        ALUout_M = 32'h0000_0013;
        PC8_M    = 32'h0040_0100;
        @(posedge clk);
        #1;
        check("rtype.instr", instr_W, 32'h012A_4020);
        check("rtype.alu", ALUout_W, 32'h0000_0013);
        check("rtype.pc8", PC8_W, 32'h0040_0100);
        chk_ld("rtype", 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DM_WORDS, default 1024, is the data memory depth in 32-bit words, giving a 4 KiB byte space.
REQ-002 Parameter AW, default 10, is the word-index width; it SHALL equal log2(DM_WORDS).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port instr_M, input, 32 bits: instruction currently in the memory stage.
REQ-006 Port ALUout_M, input, 32 bits: ALU result, used as byte address for loads and stores.
REQ-007 Port WD_M, input, 32 bits: store data, already forwarded upstream.
REQ-008 Port PC8_M, input, 32 bits: link value (PC+8) of instr_M.
REQ-009 Port instr_W, output, 32 bits: registered instr_M.
REQ-010 Port ALUout_W, output, 32 bits: registered ALUout_M.
REQ-011 Port DR_W, output, 32 bits: registered, extended load data.
REQ-012 Port PC8_W, output, 32 bits: registered PC8_M.
REQ-013 Port addr_err_W, output, 1 bit: registered misalignment flag for instr_W.

Function
REQ-014 Decode SHALL use opcode instr_M[31:26]: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000.
- Any other opcode is a non-memory instruction.
REQ-015 Addressing SHALL use word index ALUout_M[AW+1:2] and byte offset ALUout_M[1:0].
- Bits above AW+1 SHALL be ignored, so addresses wrap modulo 4 KiB.
REQ-016 Alignment rules:
- Word access is misaligned when offset is not 0.
- Halfword access is misaligned when offset[0] is 1.
- Byte access is never misaligned.
REQ-017 An aligned sw SHALL write WD_M to the addressed word at the rising edge.
REQ-018 An aligned sh SHALL write WD_M[15:0] into byte lanes 1:0 (offset 0) or 3:2 (offset 2); other lanes SHALL be unchanged.
REQ-019 sb SHALL write WD_M[7:0] into byte lane offset; other lanes SHALL be unchanged.
REQ-020 A misaligned store SHALL NOT modify memory.
REQ-021 Memory read SHALL be combinational from the word index.
- The selected byte or halfword SHALL be sign-extended for lb and lh, and zero-extended for lbu and lhu.
- lw SHALL pass the word through unchanged.
REQ-022 DR_W SHALL capture the extended load data at the rising edge.
- DR_W SHALL capture 0 for a misaligned load and for any non-load instruction.
REQ-023 On each rising edge, instr_W, ALUout_W and PC8_W SHALL load instr_M, ALUout_M and PC8_M. Latency is exactly 1 cycle, with no stall or flush.
REQ-024 addr_err_W SHALL capture 1 when instr_M is a misaligned load or store, and 0 otherwise.
REQ-025 Store followed by load to the same word in the next cycle:
- The load SHALL observe the stored value, since the write completes at the edge before the load's combinational read.
REQ-026 Load and store opcodes SHALL both be honoured every cycle; there are no back-pressure or handshake signals.

Reset
REQ-027 While reset is low, instr_W, ALUout_W, DR_W, PC8_W and addr_err_W SHALL be 0 immediately, independent of clk.
REQ-028 While reset is low, all DM_WORDS memory words SHALL be cleared to 0, and no store SHALL take effect.
REQ-029 On reset deassertion, the first rising edge SHALL perform normal operation.
REQ-030 Reset asserted mid-stream SHALL discard the in-flight instruction; instr_W SHALL read 0 (nop).

Verification
REQ-031 sw WD_M=0x12345678 at addr 0x10, then lw addr 0x10 -> DR_W=0x12345678, addr_err_W=0.
REQ-032 After REQ-031, sb WD_M=0xAB at 0x11; then lb 0x11 -> DR_W=0xFFFFFFAB; lbu 0x11 -> DR_W=0x000000AB; lw 0x10 -> DR_W=0x1234AB78.
REQ-033 sh WD_M=0x8001 at 0x22; then lh 0x22 -> DR_W=0xFFFF8001; lhu 0x22 -> DR_W=0x00008001; lw 0x20 -> DR_W=0x80010000.
REQ-034 sw at 0x31 (misaligned), then lw 0x30 -> memory word still 0; the store's addr_err_W=1; the subsequent lw's DR_W=0.
REQ-035 Address wrap: sw 0xCAFEF00D at 0x00001004, then lw 0x00000004 -> DR_W=0xCAFEF00D.
REQ-036 Reset pulsed low mid-sequence between clock edges -> all outputs 0 at once; lw 0x10 afterward -> DR_W=0; an R-type instr_M passes to instr_W one cycle later with DR_W=0.
